// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    localparam int UART_MIN_BITS = 5;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2
    } uart_rx_fsm_e;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_EVEN  = 2'b01,
        PAR_ODD   = 2'b10,
        PAR_STICK = 2'b11
    } uart_parity_e;

    typedef struct packed {
        logic parity;
        logic frame;
        logic overrun;
    } uart_err_t;

    // Codes above 4 select the widest (9-bit) field.
    function automatic logic [3:0] uart_data_bits(input logic [2:0] code);
        return (code > 3'd4) ? 4'd9 : 4'(code) + 4'(UART_MIN_BITS);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: wraps every div_i+1 clocks and flags mid-bit and end-of-bit.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_half_o,
    output logic                 tick_full_o
);

    logic [DIV_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)   cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else            cnt_q <= cnt_q + 1'b1;
    end

    assign tick_half_o = (cnt_q == (div_i >> 1));
    assign tick_full_o = (cnt_q == div_i);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a valid/ready holding register and sticky error flags.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int MAX_BITS  = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic [2:0]           cfg_bits_i,
    input  logic [1:0]           cfg_parity_i,
    input  logic                 cfg_stop2_i,
    output logic [MAX_BITS-1:0]  rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 busy_o,
    output logic                 err_parity_o,
    output logic                 err_frame_o,
    output logic                 err_overrun_o,
    input  logic                 err_clr_i
);

    uart_rx_fsm_e        state_q;
    logic [2:0]          sync_q;
    logic [3:0]          bit_cnt_q;
    logic [MAX_BITS-1:0] shreg_q;
    logic                par_q;
    logic                tick_half, tick_full, baud_clr;
    logic                smp_tick, smp_bit, exp_par;
    logic                start_edge, frame_done;
    logic [3:0]          nbits;
    uart_parity_e        par_mode;
    uart_err_t           err_set;

    // sync_q[1] is the synchronised line, sync_q[2] its one-cycle history.
    assign start_edge = !sync_q[1] && sync_q[2];
    assign baud_clr   = (state_q == RX_IDLE) || tick_full;
    assign busy_o     = (state_q != RX_IDLE);
    assign nbits      = uart_data_bits(cfg_bits_i);
    assign par_mode   = uart_parity_e'(cfg_parity_i);

    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (baud_clr),
        .div_i       (cfg_div_i),
        .tick_half_o (tick_half),
        .tick_full_o (tick_full)
    );

`ifdef UART_RX_MAJORITY_EN
    logic       tick_half_q;
    logic [1:0] smp_hist_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_half_q <= 1'b0;
            smp_hist_q  <= 2'b11;
        end else begin
            tick_half_q <= tick_half;
            smp_hist_q  <= {smp_hist_q[0], sync_q[1]};
        end
    end

    // Decide one clock after mid-bit, voting over mid-1, mid and mid+1.
    assign smp_tick = tick_half_q;
    assign smp_bit  = maj3(smp_hist_q[1], smp_hist_q[0], sync_q[1]);
`else
    assign smp_tick = tick_half;
    assign smp_bit  = sync_q[1];
`endif

    always_comb begin
        unique case (par_mode)
            PAR_EVEN: exp_par = par_q;
            PAR_ODD:  exp_par = ~par_q;
            default:  exp_par = 1'b1;
        endcase
    end

    assign frame_done = cfg_en_i && smp_tick &&
                        (((state_q == RX_STOP1) && !cfg_stop2_i) || (state_q == RX_STOP2));

    always_comb begin
        err_set = '0;
        if (cfg_en_i && smp_tick) begin
            err_set.parity  = (state_q == RX_PARITY) && (smp_bit != exp_par);
            err_set.frame   = ((state_q == RX_STOP1) || (state_q == RX_STOP2)) && !smp_bit;
            err_set.overrun = frame_done && rx_valid_o && !rx_ready_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RX_IDLE;
            sync_q    <= '1;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
        end else if (!cfg_en_i) begin
            state_q <= RX_IDLE;
            sync_q  <= '1;
        end else begin
            sync_q <= {sync_q[1], sync_q[0], rx_i};
            unique case (state_q)
                RX_IDLE: begin
                    if (start_edge) begin
                        state_q   <= RX_START;
                        shreg_q   <= '0;
                        bit_cnt_q <= '0;
                        par_q     <= 1'b0;
                    end
                end
                RX_START: begin
                    if (smp_tick) state_q <= smp_bit ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (smp_tick) begin
                        shreg_q[bit_cnt_q] <= smp_bit;
                        par_q              <= par_q ^ smp_bit;
                        bit_cnt_q          <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == nbits - 4'd1)
                            state_q <= (par_mode == PAR_NONE) ? RX_STOP1 : RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    if (smp_tick) state_q <= RX_STOP1;
                end
                RX_STOP1: begin
                    if (smp_tick) state_q <= cfg_stop2_i ? RX_STOP2 : RX_IDLE;
                end
                RX_STOP2: begin
                    if (smp_tick) state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    // Holding register: a completed frame is dropped only if the old word is still unread.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            err_parity_o  <= 1'b0;
            err_frame_o   <= 1'b0;
            err_overrun_o <= 1'b0;
        end else begin
            if (frame_done && !(rx_valid_o && !rx_ready_i)) begin
                rx_data_o  <= shreg_q;
                rx_valid_o <= 1'b1;
            end else if (rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
            err_parity_o  <= err_set.parity  | (err_parity_o  & ~err_clr_i);
            err_frame_o   <= err_set.frame   | (err_frame_o   & ~err_clr_i);
            err_overrun_o <= err_set.overrun | (err_overrun_o & ~err_clr_i);
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: serial frames are built from the frame rules, expected words queued.
`timescale 1ns/1ps
module tb_uart_rx_os;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        rx_i = 1'b1;
    logic        cfg_en_i = 1'b0;
    logic [15:0] cfg_div_i = 16'd15;
    logic [2:0]  cfg_bits_i = 3'd3;
    logic [1:0]  cfg_parity_i = 2'b00;
    logic        cfg_stop2_i = 1'b0;
    logic [8:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        busy_o;
    logic        err_parity_o, err_frame_o, err_overrun_o;
    logic        err_clr_i = 1'b0;

    uart_rx_os #(.DIV_WIDTH(16), .MAX_BITS(9)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .rx_i          (rx_i),
        .cfg_en_i      (cfg_en_i),
        .cfg_div_i     (cfg_div_i),
        .cfg_bits_i    (cfg_bits_i),
        .cfg_parity_i  (cfg_parity_i),
        .cfg_stop2_i   (cfg_stop2_i),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .busy_o        (busy_o),
        .err_parity_o  (err_parity_o),
        .err_frame_o   (err_frame_o),
        .err_overrun_o (err_overrun_o),
        .err_clr_i     (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [8:0] data;
        bit         perr;
        bit         ferr;
        bit         ovr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   stop_cyc = 0;
    int   present_cyc = 0;
    int   rdy_mode = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input bit s2);
        cfg_div_i    = 16'(div);
        cfg_bits_i   = 3'(bits);
        cfg_parity_i = 2'(par);
        cfg_stop2_i  = s2;
    endtask

    task automatic clr_err();
        err_clr_i = 1'b1;
        tick(1);
        err_clr_i = 1'b0;
        tick(1);
    endtask

    // Drives one frame with the current configuration; optionally queues the expected word.
    task automatic send_frame(input logic [8:0] data, input bit bad_par, input bit bad_s1,
                              input bit bad_s2, input bit push);
        int   bp, nb;
        logic pbit;
        exp_t e;
        bp = int'(cfg_div_i) + 1;
        nb = (cfg_bits_i > 3'd4) ? 9 : int'(cfg_bits_i) + 5;
        e.data = '0;
        for (int i = 0; i < nb; i++) e.data[i] = data[i];
        case (cfg_parity_i)
            2'b01:   pbit = ($countones(e.data) % 2) == 1;
            2'b10:   pbit = ($countones(e.data) % 2) == 0;
            default: pbit = 1'b1;
        endcase
        e.perr = (cfg_parity_i != 2'b00) && bad_par;
        e.ferr = bad_s1 || (cfg_stop2_i && bad_s2);
        e.ovr  = 1'b0;
        if (push) sb_q.push_back(e);
        rx_i = 1'b0;
        tick(bp);
        for (int i = 0; i < nb; i++) begin
            rx_i = data[i];
            tick(bp);
        end
        if (cfg_parity_i != 2'b00) begin
            rx_i = pbit ^ bad_par;
            tick(bp);
        end
        stop_cyc = cyc;
        rx_i = ~bad_s1;
        tick(bp);
        if (cfg_stop2_i) begin
            stop_cyc = cyc;
            rx_i = ~bad_s2;
            tick(bp);
        end
        rx_i = 1'b1;
    endtask

    task automatic wait_empty(input int max_cyc);
        int n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            tick(1);
            n++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL word_timeout: %0d words outstanding, wanted 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Ready driver.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            case (rdy_mode)
                0:       rx_ready_i = 1'b0;
                1:       rx_ready_i = 1'b1;
                default: rx_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares each newly presented word against the head of the queue.
    initial begin
        bit   v_prev = 1'b0;
        bit   hs_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i && rx_valid_o && (!v_prev || hs_prev)) begin
                present_cyc = cyc;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got 0x%0h, wanted no word", rx_data_o);
                end else begin
                    e = sb_q.pop_front();
                    check("word_data", 32'(rx_data_o), 32'(e.data));
                    check("word_err_parity", 32'(err_parity_o), 32'(e.perr));
                    check("word_err_frame", 32'(err_frame_o), 32'(e.ferr));
                    check("word_err_overrun", 32'(err_overrun_o), 32'(e.ovr));
                end
            end
            v_prev  = rx_valid_o;
            hs_prev = rx_valid_o && rx_ready_i;
        end
    end

    initial begin
        #800000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int bp;
        tick(3);
        check("rst_data", 32'(rx_data_o), 0);
        check("rst_valid", 32'(rx_valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_err_parity", 32'(err_parity_o), 0);
        check("rst_err_frame", 32'(err_frame_o), 0);
        check("rst_err_overrun", 32'(err_overrun_o), 0);
        rst_n_i = 1'b1;
        tick(2);
        cfg_en_i = 1'b1;
        rdy_mode = 1;
        tick(4);

        // 8N1, 0xA5, word must appear within the stop bit
        set_cfg(15, 3, 0, 0);
        send_frame(9'h0A5, 0, 0, 0, 1);
        tick(16);
        wait_empty(200);
        check("a5_present_in_stop_bit",
              32'((present_cyc - stop_cyc >= 1) && (present_cyc - stop_cyc <= 16)), 1);

        // 9 bits odd parity, all ones, wrong parity bit on the line
        clr_err();
        set_cfg(15, 4, 2, 0);
        send_frame(9'h1FF, 1, 0, 0, 1);
        tick(16);
        wait_empty(200);

        // 8N2 with a bad second stop bit, then clear
        clr_err();
        set_cfg(15, 3, 0, 1);
        send_frame(9'h03C, 0, 0, 1, 1);
        tick(16);
        wait_empty(200);
        clr_err();
        check("frame_err_cleared", 32'(err_frame_o), 0);

        // Error set while clear is held: set wins
        set_cfg(15, 3, 0, 0);
        err_clr_i = 1'b1;
        send_frame(9'h081, 0, 1, 0, 1);
        tick(4);
        err_clr_i = 1'b0;
        tick(16);
        wait_empty(200);
        clr_err();

        // Overrun: second frame arrives while first is unread
        rdy_mode = 0;
        tick(2);
        send_frame(9'h011, 0, 0, 0, 1);
        tick(16);
        send_frame(9'h022, 0, 0, 0, 0);
        tick(20);
        wait_empty(200);
        check("ovr_valid_held", 32'(rx_valid_o), 1);
        check("ovr_old_data", 32'(rx_data_o), 32'h011);
        check("ovr_flag", 32'(err_overrun_o), 1);
        rdy_mode = 1;
        tick(3);
        check("ovr_drained", 32'(rx_valid_o), 0);
        clr_err();
        check("ovr_flag_cleared", 32'(err_overrun_o), 0);

        // False start: line low for 3 clocks
        rx_i = 1'b0;
        tick(3);
        rx_i = 1'b1;
        tick(1);
        check("false_start_busy", 32'(busy_o), 1);
        tick(20);
        check("false_start_idle", 32'(busy_o), 0);

        // Enable dropped mid-DATA, then a clean 0x5A frame
        rx_i = 1'b0;
        tick(16);
        rx_i = 1'b0;
        tick(16);
        rx_i = 1'b1;
        tick(16);
        rx_i = 1'b0;
        tick(8);
        check("en_drop_busy_before", 32'(busy_o), 1);
        cfg_en_i = 1'b0;
        tick(1);
        check("en_drop_busy_after", 32'(busy_o), 0);
        rx_i = 1'b1;
        tick(10);
        cfg_en_i = 1'b1;
        tick(5);
        send_frame(9'h05A, 0, 0, 0, 1);
        tick(16);
        wait_empty(200);

        // Randomised frames over the configuration space
        rdy_mode = 2;
        for (int k = 0; k < 30; k++) begin
            clr_err();
            set_cfg($urandom_range(4, 20), $urandom_range(0, 7), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
            bp = int'(cfg_div_i) + 1;
            send_frame(9'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 5) == 0), 1);
            tick(2 * bp);
            wait_empty(20 * bp);
        end

        tick(10);
        check("final_no_busy", 32'(busy_o), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
